ex_stage: RTL and testbench

- Execute stage of the 5-stage RV32 pipeline. Sits directly downstream of the ALU control decoder.
- Registers the decoded ID outputs in an ID/EX register with stall and flush, and applies forwarding muxes.
- Runs the ALU on the 3-bit ALUControl code and resolves beq.
- Registers results into EX/MEM for the memory stage.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 32 +++
 rtl/ex_stage.sv | 159 +++++++++++++++
 tb/tb_ex_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control and forwarding encodings used by decode, hazard unit and execute.
package alu_pkg;

    localparam int unsigned ALU_W  = 3;
    localparam int unsigned FWD_W  = 2;
    localparam int unsigned RSRC_W = 2;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;
    localparam logic [ALU_W-1:0] ALU_SLL = 3'b110;

    localparam logic [FWD_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32 ALU driven by the 3-bit ALUControl code; unused codes yield 0.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [ALU_W-1:0] alu_control,
    output logic [XLEN-1:0]  result,
    output logic             zero
);

    localparam int unsigned SHW = $clog2(XLEN);

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            // Shift amount uses only the low bits of b.
            ALU_SLL: result = a << b[SHW-1:0];
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register with stall/flush, forwarding muxes, ALU, beq resolve, EX/MEM register.
module ex_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_e,
    input  logic              flush_e,
    input  logic              valid_d,
    input  logic [ALU_W-1:0]  alu_control_d,
    input  logic              alu_src_d,
    input  logic              reg_write_d,
    input  logic              mem_write_d,
    input  logic [RSRC_W-1:0] result_src_d,
    input  logic              branch_d,
    input  logic [XLEN-1:0]   rd1_d,
    input  logic [XLEN-1:0]   rd2_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic [RA_W-1:0]   rs1_d,
    input  logic [RA_W-1:0]   rs2_d,
    input  logic [RA_W-1:0]   rd_d,
    input  logic [FWD_W-1:0]  forward_a_e,
    input  logic [FWD_W-1:0]  forward_b_e,
    input  logic [XLEN-1:0]   result_w,
    output logic [RA_W-1:0]   rs1_e,
    output logic [RA_W-1:0]   rs2_e,
    output logic [RA_W-1:0]   rd_e,
    output logic              pc_src_e,
    output logic [XLEN-1:0]   pc_target_e,
    output logic              valid_m,
    output logic              reg_write_m,
    output logic              mem_write_m,
    output logic [RSRC_W-1:0] result_src_m,
    output logic [XLEN-1:0]   alu_result_m,
    output logic [XLEN-1:0]   write_data_m,
    output logic [RA_W-1:0]   rd_m
);

    typedef struct packed {
        logic              valid;
        logic [ALU_W-1:0]  alu_control;
        logic              alu_src;
        logic              reg_write;
        logic              mem_write;
        logic [RSRC_W-1:0] result_src;
        logic              branch;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [RA_W-1:0]   rs1;
        logic [RA_W-1:0]   rs2;
        logic [RA_W-1:0]   rd;
    } id_ex_t;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              mem_write;
        logic [RSRC_W-1:0] result_src;
        logic [XLEN-1:0]   alu_result;
        logic [XLEN-1:0]   write_data;
        logic [RA_W-1:0]   rd;
    } ex_mem_t;

    id_ex_t  id_ex_q, id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result;
    logic            alu_zero;

    function automatic logic [XLEN-1:0] fwd_mux(input logic [FWD_W-1:0] sel,
                                                input logic [XLEN-1:0]  reg_v,
                                                input logic [XLEN-1:0]  wb_v,
                                                input logic [XLEN-1:0]  mem_v);
        case (sel)
            FWD_WB:  return wb_v;
            FWD_MEM: return mem_v;
            default: return reg_v;
        endcase
    endfunction

    // ID/EX next state: flush beats stall, stall holds, otherwise capture decode.
    always_comb begin
        id_ex_d = id_ex_q;
        if (flush_e) begin
            id_ex_d = '0;
        end else if (!stall_e) begin
            id_ex_d.valid       = valid_d;
            id_ex_d.alu_control = alu_control_d;
            id_ex_d.alu_src     = alu_src_d;
            id_ex_d.reg_write   = reg_write_d;
            id_ex_d.mem_write   = mem_write_d;
            id_ex_d.result_src  = result_src_d;
            id_ex_d.branch      = branch_d;
            id_ex_d.rd1         = rd1_d;
            id_ex_d.rd2         = rd2_d;
            id_ex_d.imm         = imm_d;
            id_ex_d.pc          = pc_d;
            id_ex_d.rs1         = rs1_d;
            id_ex_d.rs2         = rs2_d;
            id_ex_d.rd          = rd_d;
        end
    end

    always_comb begin
        src_a = fwd_mux(forward_a_e, id_ex_q.rd1, result_w, ex_mem_q.alu_result);
        fwd_b = fwd_mux(forward_b_e, id_ex_q.rd2, result_w, ex_mem_q.alu_result);
        src_b = id_ex_q.alu_src ? id_ex_q.imm : fwd_b;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a           (src_a),
        .b           (src_b),
        .alu_control (id_ex_q.alu_control),
        .result      (alu_result),
        .zero        (alu_zero)
    );

    // EX/MEM never stalls; side-effecting controls are qualified by valid.
    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.valid      = id_ex_q.valid;
        ex_mem_d.reg_write  = id_ex_q.valid & id_ex_q.reg_write;
        ex_mem_d.mem_write  = id_ex_q.valid & id_ex_q.mem_write;
        ex_mem_d.result_src = id_ex_q.result_src;
        ex_mem_d.alu_result = alu_result;
        ex_mem_d.write_data = fwd_b;
        ex_mem_d.rd         = id_ex_q.rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
        end
    end

    assign rs1_e        = id_ex_q.rs1;
    assign rs2_e        = id_ex_q.rs2;
    assign rd_e         = id_ex_q.rd;
    assign pc_src_e     = id_ex_q.valid & id_ex_q.branch & alu_zero;
    assign pc_target_e  = id_ex_q.pc + id_ex_q.imm;
    assign valid_m      = ex_mem_q.valid;
    assign reg_write_m  = ex_mem_q.reg_write;
    assign mem_write_m  = ex_mem_q.mem_write;
    assign result_src_m = ex_mem_q.result_src;
    assign alu_result_m = ex_mem_q.alu_result;
    assign write_data_m = ex_mem_q.write_data;
    assign rd_m         = ex_mem_q.rd;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed literal cases plus randomized traffic against a behavioural model.
module tb_ex_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, stall_e, flush_e, valid_d, alu_src_d, reg_write_d, mem_write_d, branch_d;
    logic [2:0]  alu_control_d;
    logic [1:0]  result_src_d, forward_a_e, forward_b_e;
    logic [31:0] rd1_d, rd2_d, imm_d, pc_d, result_w;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [4:0]  rs1_e, rs2_e, rd_e, rd_m;
    logic        pc_src_e, valid_m, reg_write_m, mem_write_m;
    logic [31:0] pc_target_e, alu_result_m, write_data_m;
    logic [1:0]  result_src_m;

    always #5 clk = ~clk;

    ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .alu_control_d(alu_control_d), .alu_src_d(alu_src_d), .reg_write_d(reg_write_d),
        .mem_write_d(mem_write_d), .result_src_d(result_src_d), .branch_d(branch_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .pc_d(pc_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e), .result_w(result_w),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
        .result_src_m(result_src_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
        .rd_m(rd_m)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Model: the instruction currently executing, and the values the memory stage holds.
    typedef struct packed {
        bit v; bit [2:0] op; bit use_imm; bit rw; bit mw; bit [1:0] rsrc; bit br;
        bit [31:0] a; bit [31:0] b; bit [31:0] imm; bit [31:0] pc;
        bit [4:0] s1; bit [4:0] s2; bit [4:0] d;
    } instr_t;

    instr_t    ex;
    bit        m_v, m_rw, m_mw;
    bit [1:0]  m_rsrc;
    bit [31:0] m_alu, m_wd;
    bit [4:0]  m_rd;

    function automatic bit [31:0] alu_ref(input bit [2:0] op, input bit [31:0] a, input bit [31:0] b);
        int signed sa, sb;
        sa = a; sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << (b % 32);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit [31:0] pick(input bit [1:0] sel, input bit [31:0] own);
        if (sel == 2'd1) return result_w;
        if (sel == 2'd2) return m_alu;
        return own;
    endfunction

    function automatic bit [31:0] ex_b_fwd();
        return pick(forward_b_e, ex.b);
    endfunction

    function automatic bit [31:0] ex_result();
        bit [31:0] opb;
        opb = ex.use_imm ? ex.imm : ex_b_fwd();
        return alu_ref(ex.op, pick(forward_a_e, ex.a), opb);
    endfunction

    function automatic void model_reset();
        ex = '0; m_v = 0; m_rw = 0; m_mw = 0; m_rsrc = 0; m_alu = 0; m_wd = 0; m_rd = 0;
    endfunction

    function automatic void model_edge();
        bit [31:0] r, wd;
        r  = ex_result();
        wd = ex_b_fwd();
        m_v = ex.v; m_rw = ex.v && ex.rw; m_mw = ex.v && ex.mw; m_rsrc = ex.rsrc;
        m_alu = r; m_wd = wd; m_rd = ex.d;
        if (flush_e) ex = '0;
        else if (!stall_e)
            ex = '{valid_d, alu_control_d, alu_src_d, reg_write_d, mem_write_d, result_src_d,
                   branch_d, rd1_d, rd2_d, imm_d, pc_d, rs1_d, rs2_d, rd_d};
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rs1_e", 32'(rs1_e), 32'(ex.s1));
            chk("rs2_e", 32'(rs2_e), 32'(ex.s2));
            chk("rd_e", 32'(rd_e), 32'(ex.d));
            chk("pc_src_e", 32'(pc_src_e), 32'(ex.v && ex.br && (ex_result() == 0)));
            chk("pc_target_e", pc_target_e, ex.pc + ex.imm);
            chk("valid_m", 32'(valid_m), 32'(m_v));
            chk("reg_write_m", 32'(reg_write_m), 32'(m_rw));
            chk("mem_write_m", 32'(mem_write_m), 32'(m_mw));
            chk("result_src_m", 32'(result_src_m), 32'(m_rsrc));
            chk("alu_result_m", alu_result_m, m_alu);
            chk("write_data_m", write_data_m, m_wd);
            chk("rd_m", 32'(rd_m), 32'(m_rd));
        end
    end

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic set_instr(input bit [2:0] op, input bit src, input bit [31:0] a, input bit [31:0] b,
                             input bit [31:0] imm, input bit [31:0] pc, input bit br);
        valid_d = 1; alu_control_d = op; alu_src_d = src; reg_write_d = !br; mem_write_d = 0;
        result_src_d = 2'd0; branch_d = br; rd1_d = a; rd2_d = b; imm_d = imm; pc_d = pc;
        rs1_d = 5'd1; rs2_d = 5'd2; rd_d = 5'd3;
    endtask

    task automatic bubble();
        valid_d = 0; reg_write_d = 0; mem_write_d = 0; branch_d = 0;
    endtask

    task automatic run_one(input bit [2:0] op, input bit src, input bit [31:0] a, input bit [31:0] b,
                           input bit [31:0] imm, output bit [31:0] res);
        set_instr(op, src, a, b, imm, 32'h0, 1'b0);
        cyc();
        bubble();
        cyc();
        res = alu_result_m;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [31:0] res;
        rst = 1; stall_e = 0; flush_e = 0; forward_a_e = 0; forward_b_e = 0; result_w = 0;
        set_instr(3'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        bubble();
        model_reset();
        repeat (2) cyc();
        rst = 0;
        cmp_en = 1;

        // ADD with immediate: 5 + 7 two edges later.
        set_instr(ALU_ADD, 1'b1, 32'd5, 32'd0, 32'd7, 32'h0, 1'b0);
        cyc(); cyc();
        chk("add_imm_result", alu_result_m, 32'd12);
        chk("add_imm_regwrite", 32'(reg_write_m), 32'd1);

        // beq taken in EX, then reset mid-stream kills it.
        set_instr(ALU_SUB, 1'b0, 32'd9, 32'd9, 32'h20, 32'h100, 1'b1);
        cyc();
        chk("beq_taken", 32'(pc_src_e), 32'd1);
        chk("beq_target", pc_target_e, 32'h120);
        #2;
        rst = 1;
        model_reset();
        #1;
        chk("rst_pc_src", 32'(pc_src_e), 32'd0);
        chk("rst_alu_result", alu_result_m, 32'd0);
        chk("rst_reg_write", 32'(reg_write_m), 32'd0);
        chk("rst_valid_m", 32'(valid_m), 32'd0);
        chk("rst_rd_e", 32'(rd_e), 32'd0);
        cyc();
        rst = 0;

        // Same beq flushed on capture.
        flush_e = 1;
        cyc();
        flush_e = 0;
        chk("beq_flushed", 32'(pc_src_e), 32'd0);
        bubble();
        cyc();

        run_one(ALU_SUB, 1'b0, 32'd3, 32'd5, 32'd0, res);
        chk("sub_wrap", res, 32'hFFFF_FFFE);
        run_one(ALU_SLT, 1'b0, 32'h8000_0000, 32'd1, 32'd0, res);
        chk("slt_signed", res, 32'd1);
        run_one(ALU_SLL, 1'b0, 32'd1, 32'h21, 32'd0, res);
        chk("sll_mask", res, 32'd2);
        run_one(3'b100, 1'b0, 32'd3, 32'd5, 32'd0, res);
        chk("op100_zero", res, 32'd0);
        run_one(3'b111, 1'b0, 32'd3, 32'd5, 32'd0, res);
        chk("op111_zero", res, 32'd0);

        // Forwarding from MEM then WB.
        set_instr(ALU_ADD, 1'b1, 32'h10, 32'd0, 32'd0, 32'h0, 1'b0);
        cyc();
        set_instr(ALU_ADD, 1'b1, 32'd0, 32'd0, 32'd1, 32'h0, 1'b0);
        cyc();
        forward_a_e = FWD_MEM;
        cyc();
        chk("fwd_mem", alu_result_m, 32'h11);
        forward_a_e = FWD_WB;
        result_w = 32'h20;
        bubble();
        cyc();
        chk("fwd_wb", alu_result_m, 32'h21);
        forward_a_e = FWD_REG;

        // Stall holds, then flush overrides stall.
        set_instr(ALU_ADD, 1'b0, 32'd1, 32'd2, 32'd0, 32'h0, 1'b0);
        rs1_d = 5'd3; rd_d = 5'd7; mem_write_d = 1;
        cyc();
        stall_e = 1;
        rs1_d = 5'd9; rd_d = 5'd12;
        cyc(); cyc();
        chk("stall_rs1", 32'(rs1_e), 32'd3);
        chk("stall_rd", 32'(rd_e), 32'd7);
        flush_e = 1;
        cyc();
        chk("flush_prio_rd", 32'(rd_e), 32'd0);
        stall_e = 0; flush_e = 0;
        bubble();
        cyc();
        chk("flush_regwrite_m", 32'(reg_write_m), 32'd0);
        chk("flush_memwrite_m", 32'(mem_write_m), 32'd0);

        // Randomized traffic with occasional stalls, flushes and resets.
        for (int i = 0; i < 1500; i++) begin
            valid_d       = ($urandom_range(0, 7) != 0);
            alu_control_d = 3'($urandom_range(0, 7));
            alu_src_d     = 1'($urandom_range(0, 1));
            reg_write_d   = 1'($urandom_range(0, 1));
            mem_write_d   = 1'($urandom_range(0, 1));
            result_src_d  = 2'($urandom_range(0, 3));
            branch_d      = 1'($urandom_range(0, 1));
            rd1_d         = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            rd2_d         = ($urandom_range(0, 2) == 0) ? rd1_d : $urandom;
            imm_d         = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            pc_d          = $urandom;
            rs1_d         = 5'($urandom); rs2_d = 5'($urandom); rd_d = 5'($urandom);
            forward_a_e   = 2'($urandom_range(0, 3));
            forward_b_e   = 2'($urandom_range(0, 3));
            result_w      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            stall_e       = ($urandom_range(0, 5) == 0);
            flush_e       = ($urandom_range(0, 7) == 0);
            rst           = ($urandom_range(0, 63) == 0);
            if (rst) model_reset();
            cyc();
        end
        rst = 0;
        cyc();
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
